// File: rtl/sequence_checker_if.sv
// Symbol stream from the pattern generator plus the checker's status/statistics outputs.
// master = stream source / status consumer, slave = the checker.
interface sequence_checker_if #(
  parameter int CNT_W = 16
);
  logic             valid;
  logic [3:0]       data;
  logic             locked;
  logic [3:0]       expected;
  logic             sym_err;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] error_count;

  modport master (
    output valid, data,
    input  locked, expected, sym_err, cycle_done, cycle_count, error_count
  );

  modport slave (
    input  valid, data,
    output locked, expected, sym_err, cycle_done, cycle_count, error_count
  );
endinterface

// File: rtl/sequence_checker.sv
// Receive-side checker for the repeating A,B,E,7,F,2,0,D pattern: hunts, qualifies lock,
// flywheels through the 8-symbol cycle and keeps saturating cycle/error statistics.
module sequence_checker #(
  parameter int LOCK_LEN = 8,
  parameter int LOSS_LEN = 3,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  sequence_checker_if.slave bus
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [4:0]       run;
  logic [3:0]       miss;
  logic             locked;
  logic [3:0]       expected;
  logic             sym_err;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] error_count;

  logic             match;
  logic [2:0]       idx_inc;

  function automatic logic [3:0] pattern(input logic [2:0] i);
    case (i)
      3'd0:    return 4'hA;
      3'd1:    return 4'hB;
      3'd2:    return 4'hE;
      3'd3:    return 4'h7;
      3'd4:    return 4'hF;
      3'd5:    return 4'h2;
      3'd6:    return 4'h0;
      default: return 4'hD;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign match   = (bus.data == pattern(idx));
  assign idx_inc = idx + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      idx         <= 3'd0;
      run         <= 5'd0;
      miss        <= 4'd0;
      locked      <= 1'b0;
      expected    <= 4'hA;
      sym_err     <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_count <= '0;
      error_count <= '0;
    end else begin
      sym_err    <= 1'b0;
      cycle_done <= 1'b0;
      if (bus.valid) begin
        case (state)
          HUNT: begin
            if (bus.data == 4'hA) begin
              state    <= VERIFY;
              idx      <= 3'd1;
              run      <= 5'd1;
              expected <= pattern(3'd1);
            end
          end
          VERIFY: begin
            if (match) begin
              idx      <= idx_inc;
              run      <= run + 5'd1;
              expected <= pattern(idx_inc);
              if (run + 5'd1 == 5'(LOCK_LEN)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= 4'd0;
              end
            end else if (bus.data == 4'hA) begin
              // An unexpected A is treated as a fresh pattern start.
              idx      <= 3'd1;
              run      <= 5'd1;
              expected <= pattern(3'd1);
            end else begin
              state    <= HUNT;
              idx      <= 3'd0;
              run      <= 5'd0;
              expected <= 4'hA;
            end
          end
          LOCKED: begin
            if (match) begin
              miss     <= 4'd0;
              idx      <= idx_inc;
              expected <= pattern(idx_inc);
              if (idx == 3'd7) begin
                cycle_done  <= 1'b1;
                cycle_count <= sat_inc(cycle_count);
              end
            end else begin
              sym_err     <= 1'b1;
              error_count <= sat_inc(error_count);
              if (miss + 4'd1 == 4'(LOSS_LEN)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                idx      <= 3'd0;
                run      <= 5'd0;
                miss     <= 4'd0;
                expected <= 4'hA;
              end else begin
                // Flywheel: keep stepping through the cycle across isolated errors.
                miss     <= miss + 4'd1;
                idx      <= idx_inc;
                expected <= pattern(idx_inc);
              end
            end
          end
          default: begin
            state    <= HUNT;
            idx      <= 3'd0;
            run      <= 5'd0;
            miss     <= 4'd0;
            locked   <= 1'b0;
            expected <= 4'hA;
          end
        endcase
      end
    end
  end

  assign bus.locked      = locked;
  assign bus.expected    = expected;
  assign bus.sym_err     = sym_err;
  assign bus.cycle_done  = cycle_done;
  assign bus.cycle_count = cycle_count;
  assign bus.error_count = error_count;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed-vector bench for sequence_checker; counters narrowed to 3 bits so saturation is reachable.
module tb_sequence_checker;

  localparam int CNT_W = 3;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  sequence_checker_if #(.CNT_W(CNT_W)) bus ();

  sequence_checker #(.LOCK_LEN(8), .LOSS_LEN(3), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  // Apply one symbol (or idle cycle) and return just after the sampling edge.
  task automatic step(input logic v, input logic [3:0] d);
    @(negedge clk);
    bus.valid = v;
    bus.data  = d;
    @(posedge clk);
    #1;
  endtask

  // Valid symbol followed by a full check of the 1-cycle flags.
  task automatic sym(input string tag, input logic [3:0] d, input logic lk,
                     input logic [3:0] ex, input logic se, input logic cd);
    step(1'b1, d);
    chk({tag, ".locked"},     32'(bus.locked),     32'(lk));
    chk({tag, ".expected"},   32'(bus.expected),   32'(ex));
    chk({tag, ".sym_err"},    32'(bus.sym_err),    32'(se));
    chk({tag, ".cycle_done"}, 32'(bus.cycle_done), 32'(cd));
  endtask

  task automatic counts(input string tag, input int cc, input int ec);
    chk({tag, ".cycle_count"}, 32'(bus.cycle_count), 32'(cc));
    chk({tag, ".error_count"}, 32'(bus.error_count), 32'(ec));
  endtask

  logic [3:0] pat [8];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    pat[0] = 4'hA; pat[1] = 4'hB; pat[2] = 4'hE; pat[3] = 4'h7;
    pat[4] = 4'hF; pat[5] = 4'h2; pat[6] = 4'h0; pat[7] = 4'hD;
    bus.valid = 1'b0;
    bus.data  = 4'h0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.locked",     32'(bus.locked),     32'd0);
    chk("rst.expected",   32'(bus.expected),   32'hA);
    chk("rst.sym_err",    32'(bus.sym_err),    32'd0);
    chk("rst.cycle_done", 32'(bus.cycle_done), 32'd0);
    counts("rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: clean pattern, lock on 8th symbol, cycle_done on 16th
    for (int i = 0; i < 16; i++)
      sym($sformatf("t1[%0d]", i), pat[i % 8], i >= 7, pat[(i + 1) % 8], 1'b0, i == 15);
    counts("t1", 1, 0);

    // 2: single wrong symbol at idx 4, flywheel keeps going
    sym("t2.A", 4'hA, 1'b1, 4'hB, 1'b0, 1'b0);
    sym("t2.B", 4'hB, 1'b1, 4'hE, 1'b0, 1'b0);
    sym("t2.E", 4'hE, 1'b1, 4'h7, 1'b0, 1'b0);
    sym("t2.7", 4'h7, 1'b1, 4'hF, 1'b0, 1'b0);
    sym("t2.bad", 4'h5, 1'b1, 4'h2, 1'b1, 1'b0);
    counts("t2.bad", 1, 1);
    sym("t2.2", 4'h2, 1'b1, 4'h0, 1'b0, 1'b0);
    sym("t2.0", 4'h0, 1'b1, 4'hD, 1'b0, 1'b0);
    sym("t2.D", 4'hD, 1'b1, 4'hA, 1'b0, 1'b1);
    counts("t2", 2, 1);

    // 3: three consecutive errors drop lock, then re-lock
    sym("t3.e1", 4'h3, 1'b1, 4'hB, 1'b1, 1'b0);
    sym("t3.e2", 4'h3, 1'b1, 4'hE, 1'b1, 1'b0);
    sym("t3.e3", 4'h3, 1'b0, 4'hA, 1'b1, 1'b0);
    counts("t3.lost", 2, 4);
    for (int i = 0; i < 8; i++)
      sym($sformatf("t3.re[%0d]", i), pat[i], i == 7, pat[(i + 1) % 8], 1'b0, 1'b0);
    counts("t3", 2, 4);

    // 4: drop lock again, then restart on the second A of a broken start
    sym("t4.e1", 4'h3, 1'b1, 4'hB, 1'b1, 1'b0);
    sym("t4.e2", 4'h3, 1'b1, 4'hE, 1'b1, 1'b0);
    sym("t4.e3", 4'h3, 1'b0, 4'hA, 1'b1, 1'b0);
    counts("t4.lost", 2, 7);
    sym("t4.3",  4'h3, 1'b0, 4'hA, 1'b0, 1'b0);
    sym("t4.A1", 4'hA, 1'b0, 4'hB, 1'b0, 1'b0);
    sym("t4.B1", 4'hB, 1'b0, 4'hE, 1'b0, 1'b0);
    sym("t4.A2", 4'hA, 1'b0, 4'hB, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++)
      sym($sformatf("t4.s[%0d]", i), pat[i], i == 7, pat[(i + 1) % 8], 1'b0, 1'b0);
    counts("t4", 2, 7);

    // 5: idle cycles with garbage hold everything
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h5);
      chk($sformatf("t5.idle%0d.locked", i),   32'(bus.locked),     32'd1);
      chk($sformatf("t5.idle%0d.expected", i), 32'(bus.expected),   32'hA);
      chk($sformatf("t5.idle%0d.sym_err", i),  32'(bus.sym_err),    32'd0);
      chk($sformatf("t5.idle%0d.done", i),     32'(bus.cycle_done), 32'd0);
      counts($sformatf("t5.idle%0d", i), 2, 7);
    end
    sym("t5.A", 4'hA, 1'b1, 4'hB, 1'b0, 1'b0);
    // error_count is already all-ones: it must hold at 7
    sym("t5.sat", 4'h3, 1'b1, 4'hE, 1'b1, 1'b0);
    counts("t5.sat", 2, 7);
    sym("t5.E", 4'hE, 1'b1, 4'h7, 1'b0, 1'b0);

    // 6: reset mid-lock at idx 3 wins over a valid symbol
    @(negedge clk);
    reset     = 1'b1;
    bus.valid = 1'b1;
    bus.data  = 4'h7;
    @(posedge clk);
    #1;
    chk("t6.rst.locked",   32'(bus.locked),   32'd0);
    chk("t6.rst.expected", 32'(bus.expected), 32'hA);
    chk("t6.rst.sym_err",  32'(bus.sym_err),  32'd0);
    counts("t6.rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++)
      sym($sformatf("t6.re[%0d]", i), pat[i], i == 7, pat[(i + 1) % 8], 1'b0, 1'b0);
    counts("t6", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
